// File: rtl/des_pipeline_if.sv
// Streaming DES block interface: key/plaintext/valid in, ciphertext/valid out.
// The decrypt select exists only when DES_DECRYPT_EN is defined.
interface des_pipeline_if;
   logic [63:0] key;
   logic [63:0] plaintext;
   logic        iv;
`ifdef DES_DECRYPT_EN
   logic        decrypt;
`endif
   logic [63:0] ciphertext;
   logic        ov;

`ifdef DES_DECRYPT_EN
   modport master (output key, plaintext, iv, decrypt, input ciphertext, ov);
   modport slave (input key, plaintext, iv, decrypt, output ciphertext, ov);
`else
   modport master (output key, plaintext, iv, input ciphertext, ov);
   modport slave (input key, plaintext, iv, output ciphertext, ov);
`endif
endinterface

// File: rtl/des_pipeline.sv
// Fully pipelined DES core: one Feistel round per stage, one block per clock, 16-stage latency.
// Defining DES_DECRYPT_EN adds a per-block decrypt select carried down the pipeline.
module des_pipeline (
   input logic           clock,
   input logic           reset,
   des_pipeline_if.slave bus
);

   localparam int unsigned IpTbl [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
   };

   localparam int unsigned FpTbl [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
   };

   localparam int unsigned ETbl [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
   };

   localparam int unsigned PTbl [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
   };

   localparam int unsigned Pc1Tbl [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned Pc2Tbl [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   localparam int unsigned KeyShift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Rows of 16 in FIPS order; entry = row * 16 + column.
   localparam int unsigned SBox [8][64] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
   };

   // Tables use DES numbering (bit 1 = MSB), hence the width-minus-entry indexing.
   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IpTbl[i]];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FpTbl[i]];
      return y;
   endfunction

   function automatic logic [47:0] expand(input logic [31:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[47-i] = x[32-ETbl[i]];
      return y;
   endfunction

   function automatic logic [31:0] perm_p(input logic [31:0] x);
      logic [31:0] y;
      for (int i = 0; i < 32; i++) y[31-i] = x[32-PTbl[i]];
      return y;
   endfunction

   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      logic [55:0] y;
      for (int i = 0; i < 56; i++) y[55-i] = x[64-Pc1Tbl[i]];
      return y;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[47-i] = x[56-Pc2Tbl[i]];
      return y;
   endfunction

   function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      logic [5:0]  b;
      x = expand(r) ^ k;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         b = x[47-6*i -: 6];
         s[31-4*i -: 4] = 4'(SBox[i][{b[5], b[0], b[4:1]}]);
      end
      return perm_p(s);
   endfunction

   logic [55:0] cd_key;
   logic [27:0] c_key;
   logic [27:0] d_key;
   logic [47:0] subkey [16];

   // Subkeys follow the key combinationally; the key is treated as static configuration.
   always_comb begin
      cd_key = perm_pc1(bus.key);
      c_key  = cd_key[55:28];
      d_key  = cd_key[27:0];
      for (int k = 0; k < 16; k++) begin
         if (KeyShift[k] == 2) begin
            c_key = {c_key[25:0], c_key[27:26]};
            d_key = {d_key[25:0], d_key[27:26]};
         end else begin
            c_key = {c_key[26:0], c_key[27]};
            d_key = {d_key[26:0], d_key[27]};
         end
         subkey[k] = perm_pc2({c_key, d_key});
      end
   end

   logic [47:0] rkey [16];

`ifdef DES_DECRYPT_EN
   logic [14:0] dec_q;
   logic [15:0] dec_src;

   // Stage k sees the decrypt bit of the block it is about to process.
   always_comb begin
      dec_src = {dec_q, bus.decrypt};
      for (int k = 0; k < 16; k++) rkey[k] = dec_src[k] ? subkey[15-k] : subkey[k];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dec_q <= '0;
      end else begin
         dec_q <= dec_src[14:0];
      end
   end
`else
   always_comb begin
      for (int k = 0; k < 16; k++) rkey[k] = subkey[k];
   end
`endif

   logic [63:0] ip_out;
   logic [31:0] l_src [16];
   logic [31:0] r_src [16];
   logic [31:0] l_d   [16];
   logic [31:0] r_d   [16];
   logic [31:0] l_q   [16];
   logic [31:0] r_q   [16];
   logic [15:0] vld_q;

   always_comb begin
      ip_out   = perm_ip(bus.plaintext);
      l_src[0] = ip_out[63:32];
      r_src[0] = ip_out[31:0];
      for (int k = 1; k < 16; k++) begin
         l_src[k] = l_q[k-1];
         r_src[k] = r_q[k-1];
      end
      for (int k = 0; k < 16; k++) begin
         l_d[k] = r_src[k];
         r_d[k] = l_src[k] ^ feistel(r_src[k], rkey[k]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 16; k++) begin
            l_q[k] <= '0;
            r_q[k] <= '0;
         end
         vld_q <= '0;
      end else begin
         for (int k = 0; k < 16; k++) begin
            l_q[k] <= l_d[k];
            r_q[k] <= r_d[k];
         end
         vld_q <= {vld_q[14:0], bus.iv};
      end
   end

   // Final swap folded into the FP input ordering.
   assign bus.ciphertext = perm_fp({r_q[15], l_q[15]});
   assign bus.ov         = vld_q[15];

endmodule

// File: tb/tb_des_pipeline.sv
// Directed bench for des_pipeline: known-answer vectors, latency, bubbles, reset flush and,
// when DES_DECRYPT_EN is defined, interleaved encrypt/decrypt.
module tb_des_pipeline;
   logic clock = 1'b0;
   logic reset;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;

   des_pipeline_if bus ();

   des_pipeline dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [63:0] kat_key [6] = '{64'h133457799BBCDFF1, 64'h0000000000000000,
                                64'hFFFFFFFFFFFFFFFF, 64'h0E329232EA6D0D73,
                                64'h123556789ABDDEF0, 64'hECCBA8866443200E};
   logic [63:0] kat_pt  [6] = '{64'h0123456789ABCDEF, 64'h0000000000000000,
                                64'hFFFFFFFFFFFFFFFF, 64'h8787878787878787,
                                64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
   logic [63:0] kat_ct  [6] = '{64'h85E813540F0AB405, 64'h8CA64DE9C1B123A7,
                                64'h7359B2163E4EDC58, 64'h0000000000000000,
                                64'h85E813540F0AB405, 64'h7A17ECABF0F54BFA};

   // Known answers under the all-zero effective key; that key is weak, so pairs run both ways.
   logic [63:0] pool_pt [8] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7,
                                64'h8000000000000000, 64'h95F8A5E5DD31D900,
                                64'h4000000000000000, 64'hDD7F121CA5015619,
                                64'h2000000000000000, 64'h2E8653104F3834EA};
   logic [63:0] pool_ct [8] = '{64'h8CA64DE9C1B123A7, 64'h0000000000000000,
                                64'h95F8A5E5DD31D900, 64'h8000000000000000,
                                64'hDD7F121CA5015619, 64'h4000000000000000,
                                64'h2E8653104F3834EA, 64'h2000000000000000};

   int ivp [28] = '{1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0,
                    1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One block, then 20 idle cycles; reports first-ov cycle, its ciphertext and ov count.
   task automatic run_block(input logic [63:0] k, input logic [63:0] pt,
                            output logic [63:0] ct, output int lat, output int n_ov);
      bus.key       = k;
      bus.plaintext = pt;
      bus.iv        = 1'b1;
      lat  = 0;
      n_ov = 0;
      ct   = '0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         bus.iv        = 1'b0;
         bus.plaintext = {$urandom, $urandom};
         @(negedge clock);
         if (bus.ov === 1'b1) begin
            n_ov++;
            if (lat == 0) begin
               lat = i;
               ct  = bus.ciphertext;
            end
         end
      end
   endtask

   initial begin
      logic [63:0] ct;
      logic [63:0] ct2;
      logic [63:0] e;
      logic [63:0] q [$];
      int          lat;
      int          n_ov;
      int          blk;
      int          exp_v;

      reset         = 1'b0;
      bus.key       = '0;
      bus.plaintext = '0;
      bus.iv        = 1'b0;
`ifdef DES_DECRYPT_EN
      bus.decrypt   = 1'b0;
`endif
      #1;
      check("reset_ov", 64'(bus.ov), 64'd0);
      check("reset_ct", bus.ciphertext, 64'd0);
      repeat (3) tick();
      reset = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_block(kat_key[i], kat_pt[i], ct, lat, n_ov);
         check($sformatf("kat%0d_latency", i), 64'(lat), 64'd16);
         check($sformatf("kat%0d_ov_count", i), 64'(n_ov), 64'd1);
         check($sformatf("kat%0d_ct", i), ct, kat_ct[i]);
      end

      run_block(64'h0101010101010101, 64'h0123456789ABCDEF, ct, lat, n_ov);
      check("weak_latency", 64'(lat), 64'd16);
      run_block(64'h0101010101010101, ct, ct2, lat, n_ov);
      check("weak_roundtrip", ct2, 64'h0123456789ABCDEF);

      bus.key = 64'h0101010101010101;
      blk = 0;
      for (int t = 0; t < 46; t++) begin
         tick();
         if (t < 28 && ivp[t] == 1) begin
            bus.iv        = 1'b1;
            bus.plaintext = pool_pt[blk % 8];
            q.push_back(pool_ct[blk % 8]);
            blk++;
         end else begin
            bus.iv        = 1'b0;
            bus.plaintext = {$urandom, $urandom};
         end
         @(negedge clock);
         exp_v = (t >= 16 && t < 44) ? ivp[t-16] : 0;
         check($sformatf("stream_ov_t%0d", t), 64'(bus.ov), 64'(exp_v));
         if (exp_v == 1) begin
            e = q.pop_front();
            check($sformatf("stream_ct_t%0d", t), bus.ciphertext, e);
         end
      end

      bus.key = 64'h133457799BBCDFF1;
      for (int t = 0; t < 18; t++) begin
         tick();
         bus.iv        = 1'b1;
         bus.plaintext = {$urandom, $urandom};
      end
      @(negedge clock);
      check("pre_reset_ov", 64'(bus.ov), 64'd1);
      #1 reset = 1'b0;
      #1;
      check("midreset_ov", 64'(bus.ov), 64'd0);
      check("midreset_ct", bus.ciphertext, 64'd0);
      bus.iv = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      n_ov = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         @(negedge clock);
         if (bus.ov !== 1'b0) n_ov++;
      end
      check("post_reset_stale_ov", 64'(n_ov), 64'd0);
      run_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, ct, lat, n_ov);
      check("post_reset_latency", 64'(lat), 64'd16);
      check("post_reset_ct", ct, 64'h85E813540F0AB405);

`ifdef DES_DECRYPT_EN
      bus.key = 64'h133457799BBCDFF1;
      for (int t = 0; t < 22; t++) begin
         tick();
         if (t < 4) begin
            bus.iv        = 1'b1;
            bus.decrypt   = (t % 2 == 1);
            bus.plaintext = (t % 2 == 1) ? 64'h85E813540F0AB405 : 64'h0123456789ABCDEF;
         end else begin
            bus.iv      = 1'b0;
            bus.decrypt = 1'b0;
         end
         @(negedge clock);
         if (t >= 16 && t < 20) begin
            check($sformatf("dec_ov_t%0d", t), 64'(bus.ov), 64'd1);
            check($sformatf("dec_ct_t%0d", t), bus.ciphertext,
                  (t % 2 == 1) ? 64'h0123456789ABCDEF : 64'h85E813540F0AB405);
         end
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
